// File: rtl/date_from_day_count_pkg.sv
// Shared types and constants for the day-count to calendar-date converter.
// Optional feature macro: DOW_OUTPUT_EN (adds the day-of-week output).
package date_from_day_count_pkg;

    localparam int unsigned DAY_W   = 7;
    localparam int unsigned MONTH_W = 7;
    localparam int unsigned YEAR_W  = 15;

    // Days in one full Gregorian 400-year cycle.
    localparam logic [31:0] DAYS_400Y    = 32'd146097;
    // Day count of 32767-12-31, the last representable date.
    localparam logic [31:0] MAX_DAY_COUNT = 32'd11967899;

    // Non-leap month lengths, January first.
    localparam logic [4:0] MONTH_LEN [12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StY400,
        StY1,
        StMon,
        StFinish
    } state_e;

endpackage

// File: rtl/date_from_day_count_if.sv
// Request/result bundle for date_from_day_count.
// Optional feature macro: DOW_OUTPUT_EN (adds day_of_week).
interface date_from_day_count_if;
    import date_from_day_count_pkg::*;

    logic                 start;
    logic [31:0]          day_count;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [DAY_W-1:0]     days;
    logic [MONTH_W-1:0]   months;
    logic [YEAR_W-1:0]    years;
`ifdef DOW_OUTPUT_EN
    logic [2:0]           day_of_week;
`endif

    modport master (
        output start, day_count,
        input  busy, done, error, days, months, years
`ifdef DOW_OUTPUT_EN
        , input day_of_week
`endif
    );

    modport slave (
        input  start, day_count,
        output busy, done, error, days, months, years
`ifdef DOW_OUTPUT_EN
        , output day_of_week
`endif
    );

endinterface

// File: rtl/date_from_day_count_month_length.sv
// Combinational month length lookup: (month 1..12, leap) -> 28..31.
module month_length
    import date_from_day_count_pkg::*;
(
    input  logic [3:0] month_i,
    input  logic       leap_i,
    output logic [4:0] len_o
);

    logic [3:0] idx;

    // February depends on leap; out-of-range months fall back to 31.
    always_comb begin
        idx   = month_i - 4'd1;
        len_o = 5'd31;
        if (month_i == 4'd2) begin
            len_o = leap_i ? 5'd29 : 5'd28;
        end else if (month_i >= 4'd1 && month_i <= 4'd12) begin
            len_o = MONTH_LEN[idx];
        end
    end

endmodule

// File: rtl/date_from_day_count.sv
// Iterative converter from days-since-0001-01-01 to day/month/year.
// Peels off 400-year blocks, then single years, then months, one per cycle.
// Optional feature macro: DOW_OUTPUT_EN (registers day_of_week at finish).
module date_from_day_count
    import date_from_day_count_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    date_from_day_count_if.slave bus
);

    state_e               state_q, state_d;
    logic [31:0]          rem_q, rem_d;
    logic [6:0]           blk_q, blk_d;
    logic [8:0]           yo_q, yo_d;
    logic [3:0]           mon_q, mon_d;
    logic                 leap_q, leap_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [DAY_W-1:0]     days_q, days_d;
    logic [MONTH_W-1:0]   months_q, months_d;
    logic [YEAR_W-1:0]    years_q, years_d;
`ifdef DOW_OUTPUT_EN
    logic [31:0]          dc_q, dc_d;
    logic [2:0]           dow_q, dow_d;
`endif

    logic [9:0]           yp1;
    logic                 year_leap;
    logic [31:0]          year_len;
    logic [4:0]           mlen;

    month_length u_month_length (
        .month_i (mon_q),
        .leap_i  (leap_q),
        .len_o   (mlen)
    );

    // Leap rule within a 400-year block: every 4th year except offsets 100/200/300.
    always_comb begin
        yp1       = {1'b0, yo_q} + 10'd1;
        year_leap = (yp1[1:0] == 2'b00) && (yp1 != 10'd100) &&
                    (yp1 != 10'd200) && (yp1 != 10'd300);
        year_len  = year_leap ? 32'd366 : 32'd365;
    end

    // Next-state logic; every subtraction is gated by its compare.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        blk_d    = blk_q;
        yo_d     = yo_q;
        mon_d    = mon_q;
        leap_d   = leap_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        days_d   = days_q;
        months_d = months_q;
        years_d  = years_q;
`ifdef DOW_OUTPUT_EN
        dc_d     = dc_q;
        dow_d    = dow_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rem_d   = bus.day_count;
`ifdef DOW_OUTPUT_EN
                    dc_d    = bus.day_count;
`endif
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (rem_q > MAX_DAY_COUNT) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end else begin
                    blk_d   = '0;
                    yo_d    = '0;
                    state_d = StY400;
                end
            end
            StY400: begin
                if (rem_q >= DAYS_400Y) begin
                    rem_d = rem_q - DAYS_400Y;
                    blk_d = blk_q + 7'd1;
                end else begin
                    state_d = StY1;
                end
            end
            StY1: begin
                if (rem_q >= year_len) begin
                    rem_d = rem_q - year_len;
                    yo_d  = yo_q + 9'd1;
                end else begin
                    leap_d  = year_leap;
                    mon_d   = 4'd1;
                    state_d = StMon;
                end
            end
            StMon: begin
                if (rem_q >= {27'd0, mlen}) begin
                    rem_d = rem_q - {27'd0, mlen};
                    mon_d = mon_q + 4'd1;
                end else begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
                // On error the previous date is deliberately kept.
                if (!err_q) begin
                    days_d   = rem_q[DAY_W-1:0] + DAY_W'(1);
                    months_d = MONTH_W'(mon_q);
                    years_d  = YEAR_W'(blk_q) * YEAR_W'(400) + YEAR_W'(yo_q) + YEAR_W'(1);
`ifdef DOW_OUTPUT_EN
                    dow_d    = 3'(({1'b0, dc_q} + 33'd1) % 33'd7);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            blk_q    <= '0;
            yo_q     <= '0;
            mon_q    <= '0;
            leap_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            days_q   <= '0;
            months_q <= '0;
            years_q  <= '0;
`ifdef DOW_OUTPUT_EN
            dc_q     <= '0;
            dow_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            blk_q    <= blk_d;
            yo_q     <= yo_d;
            mon_q    <= mon_d;
            leap_q   <= leap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            days_q   <= days_d;
            months_q <= months_d;
            years_q  <= years_d;
`ifdef DOW_OUTPUT_EN
            dc_q     <= dc_d;
            dow_q    <= dow_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = err_q;
    assign bus.days   = days_q;
    assign bus.months = months_q;
    assign bus.years  = years_q;
`ifdef DOW_OUTPUT_EN
    assign bus.day_of_week = dow_q;
`endif

endmodule

// File: tb/tb_date_from_day_count.sv
// Self-checking bench for date_from_day_count with a calendar reference model.
// Optional feature macro: DOW_OUTPUT_EN (day-of-week checks).
module tb_date_from_day_count;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    date_from_day_count_if bus ();

    date_from_day_count dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Expected result of the conversion in flight.
    bit pend = 1'b0;
    int exp_d, exp_m, exp_y, exp_w;
    bit exp_e;
    // Values the outputs must currently hold.
    int hold_d = 0, hold_m = 0, hold_y = 0, hold_w = 0;
    bit hold_e = 1'b0;
    int done_cnt = 0;
    int c0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int year_len(input int y);
        return (((y % 4) == 0 && (y % 100) != 0) || (y % 400) == 0) ? 366 : 365;
    endfunction

    // Plain calendar walk: whole years from year 1, then months.
    function automatic void model(input longint n, output int d, output int m,
                                  output int y, output int w, output bit e);
        int mtab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        longint r;
        int ml;
        e = (n > 11967899);
        d = 0; m = 0; y = 0; w = 0;
        if (e) return;
        r = n;
        y = 1;
        while (r >= year_len(y)) begin
            r -= year_len(y);
            y++;
        end
        m = 1;
        forever begin
            ml = mtab[m-1] + ((m == 2 && year_len(y) == 366) ? 1 : 0);
            if (r < ml) break;
            r -= ml;
            m++;
        end
        d = int'(r) + 1;
        w = int'((n + 1) % 7);
    endfunction

    // Compare process: reset values, results on done, stability otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend   = 1'b0;
            hold_d = 0; hold_m = 0; hold_y = 0; hold_w = 0; hold_e = 1'b0;
            check("reset_busy", bus.busy, 0);
            check("reset_done", bus.done, 0);
            check("reset_error", bus.error, 0);
            check("reset_days", bus.days, 0);
            check("reset_months", bus.months, 0);
            check("reset_years", bus.years, 0);
`ifdef DOW_OUTPUT_EN
            check("reset_dow", bus.day_of_week, 0);
`endif
        end else if (bus.done) begin
            done_cnt++;
            if (!pend) begin
                check("spurious_done", bus.done, 0);
            end else begin
                pend = 1'b0;
                hold_e = exp_e;
                if (!exp_e) begin
                    hold_d = exp_d; hold_m = exp_m; hold_y = exp_y; hold_w = exp_w;
                end
                check("done_error", bus.error, hold_e);
                check("done_busy", bus.busy, 0);
                check("done_days", bus.days, hold_d);
                check("done_months", bus.months, hold_m);
                check("done_years", bus.years, hold_y);
`ifdef DOW_OUTPUT_EN
                check("done_dow", bus.day_of_week, hold_w);
`endif
            end
        end else begin
            check("hold_days", bus.days, hold_d);
            check("hold_months", bus.months, hold_m);
            check("hold_years", bus.years, hold_y);
`ifdef DOW_OUTPUT_EN
            check("hold_dow", bus.day_of_week, hold_w);
`endif
            if (!bus.busy) check("hold_error", bus.error, hold_e);
        end
    end

    task automatic pulse_start(input logic [31:0] n);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.day_count = n;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.day_count = 32'hDEAD_BEEF;
    endtask

    task automatic begin_conv(input logic [31:0] n);
        model(longint'(n), exp_d, exp_m, exp_y, exp_w, exp_e);
        pend = 1'b1;
        c0   = done_cnt;
        pulse_start(n);
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 600; i++) begin
            if (done_cnt != c0) break;
            @(negedge clk);
            #1;
        end
        check("done_count", done_cnt - c0, 1);
    endtask

    task automatic run(input logic [31:0] n);
        begin_conv(n);
        wait_done();
    endtask

    initial begin
        int d, m, y, w;
        bit e;

        // Pin the reference model with hand-computed dates.
        model(0, d, m, y, w, e);
        check("model_0_d", d, 1); check("model_0_m", m, 1); check("model_0_y", y, 1);
        check("model_0_w", w, 1);
        model(59, d, m, y, w, e);
        check("model_59_d", d, 1); check("model_59_m", m, 3); check("model_59_y", y, 1);
        model(1154, d, m, y, w, e);
        check("model_1154_d", d, 29); check("model_1154_m", m, 2);
        check("model_1154_y", y, 4);
        model(730484, d, m, y, w, e);
        check("model_2000_d", d, 31); check("model_2000_m", m, 12);
        check("model_2000_y", y, 2000); check("model_2000_w", w, 0);
        model(11967899, d, m, y, w, e);
        check("model_max_y", y, 32767); check("model_max_e", e, 0);
        model(11967900, d, m, y, w, e);
        check("model_over_e", e, 1);

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.day_count = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(32'd0);
        check("dut_0_days", bus.days, 1);
        check("dut_0_years", bus.years, 1);
`ifdef DOW_OUTPUT_EN
        check("dut_0_dow", bus.day_of_week, 1);
`endif
        run(32'd59);
        check("dut_59_months", bus.months, 3);
        run(32'd1154);
        check("dut_1154_days", bus.days, 29);
        check("dut_1154_months", bus.months, 2);
        check("dut_1154_years", bus.years, 4);
        run(32'd365);
        run(32'd146096);
        run(32'd146097);
        check("dut_401_years", bus.years, 401);
        run(32'd730484);
        check("dut_2000_days", bus.days, 31);
        check("dut_2000_months", bus.months, 12);
        check("dut_2000_years", bus.years, 2000);
`ifdef DOW_OUTPUT_EN
        check("dut_2000_dow", bus.day_of_week, 0);
`endif
        run(32'd11967899);
        check("dut_max_years", bus.years, 32767);
        run(32'd11967900);
        check("dut_over_error", bus.error, 1);
        check("dut_over_days", bus.days, 31);
        check("dut_over_years", bus.years, 32767);
        run(32'hFFFF_FFFF);
        run(32'd59);
        check("dut_after_err_error", bus.error, 0);

        // Start pulses while busy must not disturb the running conversion.
        begin_conv(32'd730484);
        repeat (5) @(posedge clk);
        pulse_start(32'd5);
        pulse_start(32'd11967900);
        wait_done();

        // Reset in the middle of the 400-year loop, with a stray start.
        begin_conv(32'd11967899);
        repeat (20) @(posedge clk);
        pulse_start(32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_years", bus.years, 0);
        check("async_rst_days", bus.days, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        c0 = done_cnt;
        repeat (600) @(posedge clk);
        check("no_done_after_reset", done_cnt - c0, 0);
        run(32'd1154);
        check("post_reset_years", bus.years, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
